alu_issue_ctrl: RTL and testbench

//  Upstream issue stage for the struct/union ALU (struct_union).
//  - Buffers incoming instr_t words in a DEPTH-entry FIFO (valid/ready in).
//  - Drives one registered instruction at a time onto the ALU's combinational input.
//  - Captures the ALU result, tags it with opcode/error and presents it downstream (valid/ready out).

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_instr_fifo.sv | 55 +++++
 rtl/alu_issue_ctrl.sv | 118 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, operand signedness, data word and the issued instruction.
package alu_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    OPC_ADD = 3'd0,
    OPC_SUB = 3'd1,
    OPC_MUL = 3'd2,
    OPC_DIV = 3'd3,
    OPC_SL  = 3'd4,
    OPC_SR  = 3'd5
  } opcode_t;

  typedef enum logic {
    OT_UNSIGNED = 1'b0,
    OT_SIGNED   = 1'b1
  } operand_type_t;

  typedef struct packed {
    opcode_t       opr;
    operand_type_t opr_type;
    data_t         opr_a;
    data_t         opr_b;
  } instr_t;

  localparam opcode_t OPC_LAST = OPC_SR;

  // Opcode encodings above OPC_LAST are illegal; divide by zero is flagged too.
  function automatic logic instr_err(input instr_t i);
    return (i.opr > OPC_LAST) || ((i.opr == OPC_DIV) && (i.opr_b == '0));
  endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// DEPTH-entry instruction queue with synchronous flush and occupancy count.
module alu_instr_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  instr_t                     din,
  output instr_t                     head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  instr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the ALU: queues instructions, drives one at a time, tags results.
// Optional statistics counters are built when ALU_ISSUE_STATS_EN is defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4
`ifdef ALU_ISSUE_STATS_EN
  ,parameter int STAT_W = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  instr_t                     in_instr,
  output instr_t                     alu_instr,
  input  data_t                      alu_result,
  output logic                       res_valid,
  input  logic                       res_ready,
  output data_t                      res_data,
  output opcode_t                    res_op,
  output logic                       res_err,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ALU_ISSUE_STATS_EN
  ,output logic [STAT_W-1:0]         stat_issued,
  output logic [STAT_W-1:0]          stat_err
`endif
);

  // state  | meaning
  // S_IDLE | no instruction in flight, waiting for the queue
  // S_EXEC | alu_instr on the ALU, result captured this cycle
  // S_HOLD | result presented, waiting for res_ready
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t state;
  instr_t head;
  logic   empty;
  logic   full;
  logic   push;
  logic   pop;
  logic   can_issue;
  logic   exec_err;

  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;
  // Flush also blocks issue so a same-cycle flush cannot leak a queued entry.
  assign can_issue = !empty && !flush;
  assign pop       = can_issue && ((state == S_IDLE) || ((state == S_HOLD) && res_ready));
  assign exec_err  = instr_err(alu_instr);

  alu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (in_instr),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      alu_instr <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= OPC_ADD;
      res_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (can_issue) begin
            alu_instr <= head;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data  <= exec_err ? '0 : alu_result;
          res_op    <= alu_instr.opr;
          res_err   <= exec_err;
          res_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (can_issue) begin
              alu_instr <= head;
              state     <= S_EXEC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Saturating counters; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_err    <= '0;
    end else begin
      if (pop && (stat_issued != '1)) stat_issued <= stat_issued + 1'b1;
      if ((state == S_EXEC) && exec_err && (stat_err != '1)) stat_err <= stat_err + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on alu_instr.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  instr_t           in_instr;
  instr_t           alu_instr;
  data_t            alu_result;
  logic             res_valid;
  logic             res_ready;
  data_t            res_data;
  opcode_t          res_op;
  logic             res_err;
  logic [CNT_W-1:0] count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]      stat_issued;
  logic [15:0]      stat_err;
`endif

  int checks = 0;
  int errors = 0;

  instr_t vec [8];
  data_t  got_data [16];
  logic [2:0] got_op [16];
  logic   got_err [16];
  int     got_cyc [16];
  int     got_n;

  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_instr  (alu_instr),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .res_err    (res_err),
    .count      (count)
`ifdef ALU_ISSUE_STATS_EN
    ,.stat_issued (stat_issued),
    .stat_err    (stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal results are junk so the DUT must zero them.
  always_comb begin
    alu_result = '0;
    case (alu_instr.opr)
      OPC_ADD: alu_result = alu_instr.opr_a + alu_instr.opr_b;
      OPC_SUB: alu_result = alu_instr.opr_a - alu_instr.opr_b;
      OPC_MUL: alu_result = alu_instr.opr_a * alu_instr.opr_b;
      OPC_DIV: alu_result = (alu_instr.opr_b == '0) ? 32'hFFFF_FFFF : alu_instr.opr_a / alu_instr.opr_b;
      OPC_SL:  alu_result = alu_instr.opr_a << alu_instr.opr_b[4:0];
      OPC_SR:  alu_result = alu_instr.opr_a >> alu_instr.opr_b[4:0];
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  function automatic instr_t mk(input logic [2:0] op, input data_t a, input data_t b);
    instr_t x;
    x          = '0;
    x.opr      = opcode_t'(op);
    x.opr_type = OT_UNSIGNED;
    x.opr_a    = a;
    x.opr_b    = b;
    return x;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_n(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_instr = vec[i];
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        checks++; errors++;
        $display("FAIL push_timeout: entry %0d never accepted", i);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int max_cycles);
    got_n = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (res_valid && res_ready && got_n < 16) begin
        got_data[got_n] = res_data;
        got_op[got_n]   = res_op;
        got_err[got_n]  = res_err;
        got_cyc[got_n]  = i;
        got_n++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; res_ready = 1'b0;
    #1;
    checks++;
    if ({res_valid, res_err, res_data, res_op, alu_instr, count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%0b err=%0b data=%h op=%0d alu=%h cnt=%0d, required all 0",
               res_valid, res_err, res_data, res_op, alu_instr, count);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    int guard;
    res_ready = 1'b0;
    vec[0] = mk(3'd0, 32'd1, 32'd2);
    push_n(1);
    guard = 0;
    while (!res_valid && guard < 10) begin @(negedge clk); guard++; end
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL hold_reached: res_valid got %0b required 1", res_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, res_err, res_data, res_op, alu_instr, count} !== '0) begin
      errors++;
      $display("FAIL reset_mid_hold: rv=%0b data=%h alu=%h cnt=%0d, required all 0", res_valid, res_data, alu_instr, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || alu_instr !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: rv=%0b alu=%h, required 0 and 0", res_valid, alu_instr);
    end
  endtask

  task automatic test_latency();
    instr_t a;
    a = mk(3'd0, 32'h10, 32'h20);
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = a;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (alu_instr === a) begin errors++; $display("FAIL latency_early: alu_instr loaded at N, required N+1"); end
    @(negedge clk);
    checks++;
    if (alu_instr !== a || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_alu: alu=%h rv=%0b, required %h and 0", alu_instr, res_valid, a);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h30 || res_op !== OPC_ADD || res_err !== 1'b0) begin
      errors++;
      $display("FAIL latency_result: rv=%0b data=%h op=%0d err=%0b, required 1 30 0 0", res_valid, res_data, res_op, res_err);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL latency_drop: res_valid got %0b required 0", res_valid); end
  endtask

  task automatic test_full();
    data_t      exp_d [5];
    logic [2:0] exp_o [5];
    vec[0] = mk(3'd0, 32'd5,    32'd3);  exp_d[0] = 32'd8;    exp_o[0] = 3'd0;
    vec[1] = mk(3'd1, 32'd10,   32'd4);  exp_d[1] = 32'd6;    exp_o[1] = 3'd1;
    vec[2] = mk(3'd2, 32'd7,    32'd6);  exp_d[2] = 32'd42;   exp_o[2] = 3'd2;
    vec[3] = mk(3'd4, 32'd1,    32'd4);  exp_d[3] = 32'd16;   exp_o[3] = 3'd4;
    vec[4] = mk(3'd5, 32'h80,   32'd3);  exp_d[4] = 32'h10;   exp_o[4] = 3'd5;
    res_ready = 1'b0;
    push_n(DEPTH + 1);
    checks++;
    if (count !== CNT_W'(DEPTH) || in_ready !== 1'b0 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_state: cnt=%0d in_ready=%0b rv=%0b, required 4 0 1", count, in_ready, res_valid);
    end
    res_ready = 1'b1;
    checks++;
    if (res_data !== exp_d[0] || res_op !== exp_o[0]) begin
      errors++;
      $display("FAIL full_first: data=%h op=%0d, required %h %0d", res_data, res_op, exp_d[0], exp_o[0]);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || count !== CNT_W'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_release: in_ready=%0b cnt=%0d, required 1 3", in_ready, count);
    end
    collect(30);
    checks++;
    if (got_n !== 4) begin errors++; $display("FAIL full_result_count: got %0d required 4", got_n); end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i+1] || got_op[i] !== exp_o[i+1] || got_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL full_order[%0d]: data=%h op=%0d err=%0b, required %h %0d 0",
                 i, got_data[i], got_op[i], got_err[i], exp_d[i+1], exp_o[i+1]);
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    vec[0] = mk(3'd3, 32'd100, 32'd0);
    vec[1] = mk(3'd7, 32'd1,   32'd2);
    vec[2] = mk(3'd3, 32'd100, 32'd7);
    res_ready = 1'b1;
    fork
      push_n(3);
      collect(20);
    join
    checks++;
    if (got_n !== 3) begin errors++; $display("FAIL err_result_count: got %0d required 3", got_n); end
    if (got_n == 3) begin
      checks++;
      if (got_err[0] !== 1'b1 || got_data[0] !== 32'd0 || got_op[0] !== 3'd3) begin
        errors++;
        $display("FAIL err_div0: err=%0b data=%h op=%0d, required 1 0 3", got_err[0], got_data[0], got_op[0]);
      end
      checks++;
      if (got_err[1] !== 1'b1 || got_data[1] !== 32'd0 || got_op[1] !== 3'd7) begin
        errors++;
        $display("FAIL err_illegal_op: err=%0b data=%h op=%0d, required 1 0 7", got_err[1], got_data[1], got_op[1]);
      end
      checks++;
      if (got_err[2] !== 1'b0 || got_data[2] !== 32'd14 || got_op[2] !== 3'd3) begin
        errors++;
        $display("FAIL err_legal_div: err=%0b data=%h op=%0d, required 0 e 3", got_err[2], got_data[2], got_op[2]);
      end
    end
`ifdef ALU_ISSUE_STATS_EN
    checks++;
    if (stat_err !== 16'd2 || stat_issued !== 16'd3) begin
      errors++;
      $display("FAIL stat_err: stat_err=%0d stat_issued=%0d, required 2 3", stat_err, stat_issued);
    end
`endif
  endtask

  task automatic test_flush();
    instr_t d;
    vec[0] = mk(3'd0, 32'd1, 32'd1);
    vec[1] = mk(3'd0, 32'd2, 32'd2);
    vec[2] = mk(3'd0, 32'd3, 32'd3);
    d      = mk(3'd0, 32'd9, 32'd9);
    res_ready = 1'b0;
    push_n(3);
    checks++;
    if (res_valid !== 1'b1 || count !== CNT_W'(2)) begin
      errors++;
      $display("FAIL flush_pre: rv=%0b cnt=%0d, required 1 2", res_valid, count);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = d;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b required 0", in_ready); end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== '0 || res_valid !== 1'b1 || res_data !== 32'd2) begin
      errors++;
      $display("FAIL flush_post: cnt=%0d rv=%0b data=%h, required 0 1 2", count, res_valid, res_data);
    end
    res_ready = 1'b1;
    collect(12);
    checks++;
    if (got_n !== 1 || got_data[0] !== 32'd2 || count !== '0) begin
      errors++;
      $display("FAIL flush_results: n=%0d first=%h cnt=%0d, required 1 2 0", got_n, got_data[0], count);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = d;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    collect(6);
    checks++;
    if (got_n !== 0 || alu_instr !== vec[0] || count !== '0) begin
      errors++;
      $display("FAIL flush_idle: n=%0d alu=%h cnt=%0d, required 0 %h 0", got_n, alu_instr, count, vec[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) vec[i] = mk(3'd0, data_t'(i + 1), data_t'(2 * (i + 1)));
    res_ready = 1'b1;
    fork
      push_n(4);
      collect(20);
    join
    checks++;
    if (got_n !== 4) begin errors++; $display("FAIL b2b_count: got %0d required 4", got_n); end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      checks++;
      if (got_data[i] !== data_t'(3 * (i + 1))) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h required %h", i, got_data[i], 3 * (i + 1));
      end
      if (i > 0) begin
        checks++;
        if (got_cyc[i] - got_cyc[i-1] !== 2) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles required 2", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
`ifdef ALU_ISSUE_STATS_EN
    checks++;
    if (stat_issued !== 16'd4) begin errors++; $display("FAIL stat_issued: got %0d required 4", stat_issued); end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_hold();
    test_latency();
    test_full();
    test_errors();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
